// File: rtl/cpu_run_ctrl.sv
// Run/stop/step sequencer between the monitor command decoder and cpu_status.
// Issues registered cpu_start/quit_cmd pulses, waits for DDR calibration and counts retired instructions.
module cpu_run_ctrl #(
  parameter int STEP_W    = 16,
  parameter int CAL_TMO   = 65535,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_step,
  input  logic              cmd_stop,
  input  logic [STEP_W-1:0] step_count,
  input  logic              init_calib_complete,
  input  logic              stall,
  input  logic              wb_retire,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              run_busy,
  output logic              step_done,
  output logic              cmd_err,
  output logic [31:0]       ret_cnt
);

  localparam int CAL_W   = (CAL_TMO > 1) ? $clog2(CAL_TMO) : 1;
  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CAL,
    RUN,
    STEP,
    STOPPING
  } state_t;

  state_t              state_reg, state_next;
  logic                mode_step_reg, mode_step_next;
  logic [STEP_W-1:0]   step_cnt_reg, step_cnt_next;
  logic [CAL_W-1:0]    cal_cnt_reg, cal_cnt_next;
  logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic [31:0]         ret_cnt_reg, ret_cnt_next;
  logic                cpu_start_reg, cpu_start_next;
  logic                quit_cmd_reg, quit_cmd_next;
  logic                run_busy_reg, run_busy_next;
  logic                step_done_reg, step_done_next;
  logic                cmd_err_reg, cmd_err_next;

  logic retire;
  logic start_win;
  logic step_win;
  logic any_cmd;

  assign retire    = wb_retire & ~stall;
  assign start_win = cmd_start & ~cmd_stop;
  assign step_win  = cmd_step & ~cmd_stop & ~cmd_start;
  assign any_cmd   = cmd_start | cmd_step | cmd_stop;

  always_comb begin
    state_next     = state_reg;
    mode_step_next = mode_step_reg;
    step_cnt_next  = step_cnt_reg;
    cal_cnt_next   = cal_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    ret_cnt_next   = ret_cnt_reg;
    cpu_start_next = 1'b0;
    quit_cmd_next  = 1'b0;
    step_done_next = 1'b0;
    cmd_err_next   = 1'b0;

    // Retires count even on the cycle a stop ends the sequence.
    if ((state_reg == RUN || state_reg == STEP) && retire) begin
      ret_cnt_next = ret_cnt_reg + 32'd1;
    end

    case (state_reg)
      IDLE: begin
        if (start_win) begin
          mode_step_next = 1'b0;
          cal_cnt_next   = '0;
          if (init_calib_complete) begin
            cpu_start_next = 1'b1;
            ret_cnt_next   = '0;
            state_next     = RUN;
          end else begin
            state_next = WAIT_CAL;
          end
        end else if (step_win) begin
          if (step_count != '0) begin
            mode_step_next = 1'b1;
            step_cnt_next  = step_count;
            cal_cnt_next   = '0;
            if (init_calib_complete) begin
              cpu_start_next = 1'b1;
              ret_cnt_next   = '0;
              state_next     = STEP;
            end else begin
              state_next = WAIT_CAL;
            end
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end

      WAIT_CAL: begin
        if (cmd_stop) begin
          // CPU was never started, so there is nothing to quit.
          state_next = IDLE;
        end else begin
          cmd_err_next = cmd_start | cmd_step;
          if (init_calib_complete) begin
            cpu_start_next = 1'b1;
            ret_cnt_next   = '0;
            state_next     = mode_step_reg ? STEP : RUN;
          end else if (cal_cnt_reg == CAL_W'(CAL_TMO - 1)) begin
            cmd_err_next = 1'b1;
            state_next   = IDLE;
          end else begin
            cal_cnt_next = cal_cnt_reg + 1'b1;
          end
        end
      end

      RUN: begin
        if (cmd_stop) begin
          quit_cmd_next  = 1'b1;
          drain_cnt_next = '0;
          state_next     = STOPPING;
        end else if (cmd_start | cmd_step) begin
          cmd_err_next = 1'b1;
        end
      end

      STEP: begin
        if (cmd_stop) begin
          quit_cmd_next  = 1'b1;
          drain_cnt_next = '0;
          state_next     = STOPPING;
        end else begin
          cmd_err_next = cmd_start | cmd_step;
          if (retire) begin
            if (step_cnt_reg == STEP_W'(1)) begin
              quit_cmd_next  = 1'b1;
              step_done_next = 1'b1;
              drain_cnt_next = '0;
              state_next     = STOPPING;
            end else begin
              step_cnt_next = step_cnt_reg - 1'b1;
            end
          end
        end
      end

      STOPPING: begin
        // Hold off new commands until the pipeline reset has drained.
        cmd_err_next = any_cmd;
        if (drain_cnt_reg == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_next = IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    run_busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_step_reg <= 1'b0;
      step_cnt_reg  <= '0;
      cal_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      cpu_start_reg <= 1'b0;
      quit_cmd_reg  <= 1'b0;
      run_busy_reg  <= 1'b0;
      step_done_reg <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_step_reg <= mode_step_next;
      step_cnt_reg  <= step_cnt_next;
      cal_cnt_reg   <= cal_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      ret_cnt_reg   <= ret_cnt_next;
      cpu_start_reg <= cpu_start_next;
      quit_cmd_reg  <= quit_cmd_next;
      run_busy_reg  <= run_busy_next;
      step_done_reg <= step_done_next;
      cmd_err_reg   <= cmd_err_next;
    end
  end

  assign cpu_start = cpu_start_reg;
  assign quit_cmd  = quit_cmd_reg;
  assign run_busy  = run_busy_reg;
  assign step_done = step_done_reg;
  assign cmd_err   = cmd_err_reg;
  assign ret_cnt   = ret_cnt_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a vector table for the main sequences plus
// hand-written calibration wait/timeout, reset-mid-step and ret_cnt wrap checks.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_start, cmd_step, cmd_stop;
  logic [15:0] step_count;
  logic        init_calib_complete, stall, wb_retire;

  logic        cpu_start, quit_cmd, run_busy, step_done, cmd_err;
  logic [31:0] ret_cnt;
  logic        cpu_start_t, quit_cmd_t, run_busy_t, step_done_t, cmd_err_t;
  logic [31:0] ret_cnt_t;

  int n_cmp;
  int n_fail;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
    .step_count(step_count), .init_calib_complete(init_calib_complete),
    .stall(stall), .wb_retire(wb_retire),
    .cpu_start(cpu_start), .quit_cmd(quit_cmd), .run_busy(run_busy),
    .step_done(step_done), .cmd_err(cmd_err), .ret_cnt(ret_cnt)
  );

  // Second copy with a short calibration timeout, fed the same stimulus.
  cpu_run_ctrl #(.CAL_TMO(8)) dut_t (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
    .step_count(step_count), .init_calib_complete(init_calib_complete),
    .stall(stall), .wb_retire(wb_retire),
    .cpu_start(cpu_start_t), .quit_cmd(quit_cmd_t), .run_busy(run_busy_t),
    .step_done(step_done_t), .cmd_err(cmd_err_t), .ret_cnt(ret_cnt_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, so;
    logic [15:0] cnt;
    logic        cal, stl, ret;
    logic        e_cs, e_q, e_b, e_sd, e_e;
    logic [31:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic so,
                              input logic [15:0] cnt, input logic cal,
                              input logic stl, input logic ret,
                              input logic e_cs, input logic e_q, input logic e_b,
                              input logic e_sd, input logic e_e,
                              input logic [31:0] e_rc);
    vec_t v;
    v.st = st; v.sp = sp; v.so = so; v.cnt = cnt;
    v.cal = cal; v.stl = stl; v.ret = ret;
    v.e_cs = e_cs; v.e_q = e_q; v.e_b = e_b; v.e_sd = e_sd; v.e_e = e_e;
    v.e_rc = e_rc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic st, input logic sp, input logic so, input logic [15:0] cnt,
                     input logic cal, input logic stl, input logic ret);
    @(negedge clk);
    cmd_start = st; cmd_step = sp; cmd_stop = so; step_count = cnt;
    init_calib_complete = cal; stall = stl; wb_retire = ret;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_start = 0; cmd_step = 0; cmd_stop = 0; step_count = 0;
    init_calib_complete = 0; stall = 0; wb_retire = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [36:0] outs();
    return {cpu_start, quit_cmd, run_busy, step_done, cmd_err, ret_cnt};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    cmd_start = 0; cmd_step = 0; cmd_stop = 0; step_count = 0;
    init_calib_complete = 0; stall = 0; wb_retire = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(outs()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Free run, rejected commands, stop and drain.
    vecs.push_back(mk(1,0,0,0,1,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,1,1, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,0,1,0,0,2));
    vecs.push_back(mk(1,0,0,0,1,0,0, 0,0,1,0,1,2));
    vecs.push_back(mk(0,1,0,5,1,0,0, 0,0,1,0,1,2));
    vecs.push_back(mk(0,0,1,0,1,0,1, 0,1,1,0,0,3));
    vecs.push_back(mk(1,0,0,0,1,0,0, 0,0,1,0,1,3));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,0,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0,0,3));
    // Zero-length step, stop+start in IDLE, lone stop in IDLE.
    vecs.push_back(mk(0,1,0,0,1,0,0, 0,0,0,0,1,3));
    vecs.push_back(mk(1,0,1,0,1,0,0, 0,0,0,0,0,3));
    vecs.push_back(mk(0,0,1,0,1,0,0, 0,0,0,0,0,3));
    // Step 3 with two stalled retires.
    vecs.push_back(mk(0,1,0,3,1,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,1,1, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,0,1,0,0,2));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0,0,2));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,1,1,1,0,3));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0,0,3));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0,0,3));
    // Step interrupted by stop with a retire in the same cycle.
    vecs.push_back(mk(0,1,0,2,1,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,1,0,1, 0,1,1,0,0,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0,0,1));
    // Start and step together: start wins without error.
    vecs.push_back(mk(1,1,0,4,1,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,1,0,1, 0,1,1,0,0,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0,0,1));
    // WAIT_CAL: repeated start errors, stop aborts without quit.
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,1,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,1,0,1,1));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0,0,1));
    // Step 1 through WAIT_CAL.
    vecs.push_back(mk(0,1,0,1,0,0,0, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1, 0,1,1,1,0,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0,0,1));

    foreach (vecs[i]) begin
      logic [36:0] exp;
      cyc(vecs[i].st, vecs[i].sp, vecs[i].so, vecs[i].cnt,
          vecs[i].cal, vecs[i].stl, vecs[i].ret);
      exp = {vecs[i].e_cs, vecs[i].e_q, vecs[i].e_b, vecs[i].e_sd, vecs[i].e_e, vecs[i].e_rc};
      $display("vec %0d: cs=%b q=%b busy=%b done=%b err=%b ret_cnt=%0d", i,
               cpu_start, quit_cmd, run_busy, step_done, cmd_err, ret_cnt);
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(exp));
    end

    // Calibration arrives 20 cycles after the start request.
    do_reset();
    cyc(1,0,0,0,0,0,0);
    chk("cal_wait_busy", 64'({cpu_start, run_busy}), 64'(2'b01));
    early = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cyc(0,0,0,0,0,0,0);
      early = early | cpu_start | cmd_err;
    end
    chk("cal_wait_no_early_start", 64'(early), 64'd0);
    cyc(0,0,0,0,1,0,0);
    $display("cal rise: cs=%b busy=%b ret_cnt=%0d", cpu_start, run_busy, ret_cnt);
    chk("cal_rise_start", 64'({cpu_start, run_busy, cmd_err}), 64'(3'b110));
    cyc(0,0,0,0,1,0,0);
    chk("cal_start_single_pulse", 64'(cpu_start), 64'd0);

    // Calibration never arrives: the CAL_TMO=8 copy aborts on cycle 8.
    do_reset();
    cyc(1,0,0,0,0,0,0);
    early = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(0,0,0,0,0,0,0);
      if (k < 8) early = early | cmd_err_t | ~run_busy_t;
    end
    $display("cal timeout: err=%b busy=%b", cmd_err_t, run_busy_t);
    chk("cal_tmo_before_limit", 64'(early), 64'd0);
    chk("cal_tmo_err_idle",
        64'({cpu_start_t, quit_cmd_t, run_busy_t, step_done_t, cmd_err_t, ret_cnt_t}),
        64'({5'b00001, 32'd0}));
    chk("cal_tmo_long_still_waiting", 64'({run_busy, cmd_err}), 64'(2'b10));
    cyc(0,0,0,0,0,0,0);
    chk("cal_tmo_err_single_pulse", 64'({cmd_err_t, run_busy_t}), 64'd0);
    cyc(0,0,1,0,0,0,0);

    // Reset while stepping with two instructions still to go.
    do_reset();
    cyc(0,1,0,4,1,0,0);
    cyc(0,0,0,0,1,0,1);
    cyc(0,0,0,0,1,0,1);
    chk("step_before_rst", 64'(outs()), 64'({5'b00100, 32'd2}));
    @(negedge clk);
    rst = 1'b1;
    wb_retire = 1'b0;
    @(posedge clk);
    #1;
    $display("rst mid-step: cs=%b q=%b busy=%b ret_cnt=%0d", cpu_start, quit_cmd, run_busy, ret_cnt);
    chk("rst_mid_step", 64'(outs()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0,0,1,0,1);
      early = early | quit_cmd | run_busy | step_done;
    end
    chk("rst_no_quit_after", 64'(early), 64'd0);

    // ret_cnt wraps at 2^32.
    do_reset();
    cyc(1,0,0,0,1,0,0);
    force dut.ret_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.ret_cnt_reg;
    cyc(0,0,0,0,1,0,1);
    chk("wrap_max", 64'(ret_cnt), 64'hFFFF_FFFF);
    cyc(0,0,0,0,1,0,1);
    $display("wrap: ret_cnt=%0d", ret_cnt);
    chk("wrap_zero", 64'(ret_cnt), 64'd0);
    cyc(0,0,0,0,1,0,1);
    chk("wrap_one", 64'(ret_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
